// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential ROM reads and queues the returned
// words with their PCs in a small prefetch FIFO. A ROM read is only started when
// the FIFO is guaranteed to have room for its data (credit-based), so the FIFO
// can never overflow. A jump flushes everything and restarts fetching at the
// target address.
module instr_fetch #(
  parameter int g_ROM_WIDTH   = 11,
  parameter int g_ROM_ADDR    = 9,
  parameter int g_INSTR_WIDTH = 9,
  parameter int g_DEPTH       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_rom_en,
  output logic [g_ROM_ADDR-1:0]    o_rom_addr,
  input  logic [g_ROM_WIDTH-1:0]   i_rom_data,
  output logic [g_INSTR_WIDTH-1:0] o_instr,
  output logic [g_ROM_ADDR-1:0]    o_instr_pc,
  output logic                     o_instr_valid,
  input  logic                     i_instr_ready,
  input  logic                     i_jump,
  input  logic [g_ROM_ADDR-1:0]    i_jump_addr
);

  localparam int c_PTR_W = (g_DEPTH > 1) ? $clog2(g_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;

  // Fetch state
  logic [g_ROM_ADDR-1:0]    r_pc;
  logic                     r_inflight;
  logic [g_ROM_ADDR-1:0]    r_inflight_pc;

  // Prefetch FIFO storage and bookkeeping
  logic [g_INSTR_WIDTH-1:0] r_mem_instr [g_DEPTH];
  logic [g_ROM_ADDR-1:0]    r_mem_pc    [g_DEPTH];
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_CNT_W-1:0]       r_count;

  logic [c_CNT_W-1:0]       w_credit_used;
  logic                     w_issue;
  logic                     w_valid;
  logic                     w_push;
  logic                     w_pop;

  // The decoder only ever sees the low instruction bits of a ROM word.
  if (g_INSTR_WIDTH < g_ROM_WIDTH) begin : g_drop_upper
    logic w_unused_rom_bits;
    assign w_unused_rom_bits = ^i_rom_data[g_ROM_WIDTH-1:g_INSTR_WIDTH];
  end

  // Buffered entries plus the one outstanding read must leave a free slot.
  assign w_credit_used = r_count + c_CNT_W'(r_inflight);
  assign w_issue       = ~i_rst & ~i_jump & (w_credit_used < c_CNT_W'(g_DEPTH));
  assign w_valid       = (r_count != {c_CNT_W{1'b0}});
  // A jump discards the data returning in its cycle instead of writing it.
  assign w_push        = r_inflight & ~i_jump;
  assign w_pop         = w_valid & i_instr_ready;

  assign o_rom_en      = w_issue;
  assign o_rom_addr    = r_pc;
  assign o_instr_valid = w_valid;

  // Head of FIFO drives the decoder; forced to zero while empty so reset is clean.
  always_comb begin
    o_instr    = {g_INSTR_WIDTH{1'b0}};
    o_instr_pc = {g_ROM_ADDR{1'b0}};
    if (w_valid) begin
      o_instr    = r_mem_instr[r_rd_ptr];
      o_instr_pc = r_mem_pc[r_rd_ptr];
    end else begin
      o_instr    = {g_INSTR_WIDTH{1'b0}};
      o_instr_pc = {g_ROM_ADDR{1'b0}};
    end
  end

  // Fetch PC and in-flight tracking; reset beats jump, jump beats sequential issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= {g_ROM_ADDR{1'b0}};
      r_inflight    <= 1'b0;
      r_inflight_pc <= {g_ROM_ADDR{1'b0}};
    end else if (i_jump) begin
      r_pc          <= i_jump_addr;
      r_inflight    <= 1'b0;
      r_inflight_pc <= r_inflight_pc;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + g_ROM_ADDR'(1);
        r_inflight_pc <= r_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a jump flushes all remaining entries.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_jump) begin
      r_wr_ptr <= {c_PTR_W{1'b0}};
      r_rd_ptr <= {c_PTR_W{1'b0}};
      r_count  <= {c_CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO data write: the returning ROM word lands at the tail with its PC.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem_instr[r_wr_ptr] <= i_rom_data[g_INSTR_WIDTH-1:0];
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model with one-cycle read latency where
// ROM[a] = a, except ROM[5] = 0x7FF to exercise dropping of the upper bits.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        rom_en;
  logic [8:0]  rom_addr;
  logic [10:0] rom_data;
  logic [8:0]  instr;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [8:0]  jump_addr;

  int n_assert;
  int n_fail;

  instr_fetch #(
    .g_ROM_WIDTH  (11),
    .g_ROM_ADDR   (9),
    .g_INSTR_WIDTH(9),
    .g_DEPTH      (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_rom_en     (rom_en),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready),
    .i_jump       (jump),
    .i_jump_addr  (jump_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] rom_word(input logic [8:0] a);
    if (a == 9'd5) return 11'h7FF;
    else           return {2'b00, a};
  endfunction

  // ROM model: data for the address presented this cycle appears next cycle.
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks that the head entry is valid with the given PC and matching instruction.
  task automatic chk_head(input string tag, input logic [8:0] pc);
    logic [10:0] w;
    w = rom_word(pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"},    {23'd0, instr_pc},    {23'd0, pc});
    chk({tag, "_instr"}, {23'd0, instr},       {23'd0, w[8:0]});
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    instr_ready = 1'b0;
    jump        = 1'b0;
    jump_addr   = 9'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_en",    {31'd0, rom_en},      32'd0);
    chk("rst_addr",  {23'd0, rom_addr},    32'd0);
    chk("rst_instr", {23'd0, instr},       32'd0);
    chk("rst_pc",    {23'd0, instr_pc},    32'd0);

    // Streaming after reset release, ready held high
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("a_c0_en",    {31'd0, rom_en},      32'd1);
    chk("a_c0_addr",  {23'd0, rom_addr},    32'd0);
    chk("a_c0_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("a_c1_valid", {31'd0, instr_valid}, 32'd0);
    chk("a_c1_addr",  {23'd0, rom_addr},    32'd1);
    tick();
    chk_head("a_c2", 9'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_head("a_seq", 9'(k));
      chk("a_seq_en", {31'd0, rom_en}, 32'd1);
    end

    // Ready low for 10 cycles: buffer fills and issue stops
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    instr_ready = 1'b0;
    repeat (4) tick();
    chk("b_c4_en", {31'd0, rom_en}, 32'd0);
    repeat (5) tick();
    chk("b_c9_en", {31'd0, rom_en}, 32'd0);
    chk_head("b_c9", 9'd0);
    tick();
    chk_head("b_c10", 9'd0);
    instr_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_head("b_drain", 9'(k));
    end

    // Jump while 3 entries are buffered and one read is in flight
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    instr_ready = 1'b0;
    repeat (4) tick();
    chk_head("c_c4", 9'd0);
    jump = 1'b1;
    jump_addr = 9'h040;
    tick();
    jump = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("c_n1_valid", {31'd0, instr_valid}, 32'd0);
    chk("c_n1_en",    {31'd0, rom_en},      32'd1);
    chk("c_n1_addr",  {23'd0, rom_addr},    32'h40);
    tick();
    chk("c_n2_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk_head("c_n3", 9'h040);
    tick();
    chk_head("c_n4", 9'h041);

    // Jump during a transfer, target near the top of the PC range
    jump = 1'b1;
    jump_addr = 9'h1FE;
    tick();
    jump = 1'b0;
    chk("d_n1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("d_n2_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk_head("d_wrap0", 9'h1FE);
    tick();
    chk_head("d_wrap1", 9'h1FF);
    tick();
    chk_head("d_wrap2", 9'h000);
    tick();
    chk_head("d_wrap3", 9'h001);

    // Back-to-back jumps: the second target wins
    jump = 1'b1;
    jump_addr = 9'h010;
    tick();
    jump_addr = 9'h020;
    #1;
    chk("e_n1_en", {31'd0, rom_en}, 32'd0);
    tick();
    jump = 1'b0;
    #1;
    chk("e_n2_valid", {31'd0, instr_valid}, 32'd0);
    chk("e_n2_addr",  {23'd0, rom_addr},    32'h20);
    tick();
    chk("e_n3_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk_head("e_n4", 9'h020);
    tick();
    chk_head("e_n5", 9'h021);

    // Reset takes priority over a simultaneous jump
    rst = 1'b1;
    jump = 1'b1;
    jump_addr = 9'h033;
    tick();
    chk("f_addr",  {23'd0, rom_addr},    32'd0);
    chk("f_valid", {31'd0, instr_valid}, 32'd0);
    chk("f_en",    {31'd0, rom_en},      32'd0);
    chk("f_pc",    {23'd0, instr_pc},    32'd0);
    rst = 1'b0;
    jump = 1'b0;
    #1;
    chk("f_rel_en",   {31'd0, rom_en},   32'd1);
    chk("f_rel_addr", {23'd0, rom_addr}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter g_ROM_WIDTH, default 11, meaning the ROM data word width.
REQ-002 The block SHALL have parameter g_ROM_ADDR, default 9, meaning the ROM address width and the PC width.
REQ-003 The block SHALL have parameter g_INSTR_WIDTH, default 9, meaning the instruction width, always <= g_ROM_WIDTH.
REQ-004 The block SHALL have parameter g_DEPTH, default 4, meaning the prefetch buffer entries, a power of 2 and >= 2.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port o_rom_en, output, 1 bit: ROM read request this cycle.
REQ-008 The block SHALL have port o_rom_addr, output, g_ROM_ADDR bits: the ROM read address.
REQ-009 The block SHALL have port i_rom_data, input, g_ROM_WIDTH bits: the ROM read data, valid one cycle after the request.
REQ-010 The block SHALL have port o_instr, output, g_INSTR_WIDTH bits: the head instruction, i_rom_data[g_INSTR_WIDTH-1:0].
REQ-011 The block SHALL have port o_instr_pc, output, g_ROM_ADDR bits: the ROM address of o_instr.
REQ-012 The block SHALL have port o_instr_valid, output, 1 bit: the head entry is present.
REQ-013 The block SHALL have port i_instr_ready, input, 1 bit: the decoder accepts the head entry.
REQ-014 The block SHALL have port i_jump, input, 1 bit: a single-cycle redirect request.
REQ-015 The block SHALL have port i_jump_addr, input, g_ROM_ADDR bits: the redirect target, sampled when i_jump=1.

Function
REQ-016 Fetch PC register: one request per issuing cycle, o_rom_addr = fetch PC; on issue, PC <= PC+1 modulo 2^g_ROM_ADDR (wraps max->0).
REQ-017 Issue rule: o_rom_en = 1 iff not i_rst, not i_jump, and (occupancy + in-flight) < g_DEPTH; o_rom_en is combinational from registered state plus i_jump.
REQ-018 In-flight tracking: a 1-bit in-flight flag is set in the issue cycle and carries that request's PC; in the next cycle, i_rom_data[g_INSTR_WIDTH-1:0] and the PC are written to the buffer tail.
REQ-019 Buffer: circular FIFO of g_DEPTH entries holding {instr, pc}; the head drives o_instr and o_instr_pc combinationally from storage; o_instr_valid = (occupancy != 0).
REQ-020 Handshake: a transfer occurs when o_instr_valid & i_instr_ready; the head pops at that edge; o_instr and o_instr_pc hold stable while valid and not ready.
REQ-021 Simultaneous push and pop: occupancy is unchanged and both occur; the credit rule of REQ-017 guarantees no overflow, so a write when full SHALL never happen.
REQ-022 Empty buffer: o_instr_valid=0; i_instr_ready is ignored; o_instr is don't-care.
REQ-023 Throughput: with i_instr_ready held at 1 and no jumps, one instruction is delivered per cycle in steady state.
REQ-024 Jump in cycle N, effect at the edge ending N: buffer flushed (occupancy 0); any in-flight return due in N+1 is discarded; fetch PC <= i_jump_addr.
REQ-025 No issue in cycle N; the target is requested in N+1; the target is valid at o_instr in N+3.
REQ-026 Jump coinciding with a transfer: the transfer counts as completed, and the flush still applies to all remaining entries.
REQ-027 Jump coinciding with an in-flight return (cycle N): the returning data is discarded, not written.
REQ-028 Back-to-back jumps: the last jump wins, and each jump restarts the REQ-025 timing.
REQ-029 Order: instructions are delivered in strictly increasing PC order (modulo wrap) between jumps, with no duplicates and no gaps.

Reset
REQ-030 While i_rst=1 at an edge: fetch PC=0, occupancy=0, in-flight=0, FIFO pointers=0, o_instr_valid=0, o_rom_en=0, and o_instr/o_instr_pc=0.
REQ-031 Reset asserted mid-operation discards all buffered and in-flight data and has priority over i_jump.
REQ-032 First cycle after deassertion: o_rom_en=1, addr 0; PC 0 is valid at o_instr two cycles later.

Verification
REQ-033 Reset release, ready=1, ROM[a]=a: o_instr_pc sequence 0,1,2,... one per cycle from cycle 2; o_rom_en never 0 after cycle 0.
REQ-034 Ready=0 for 10 cycles after reset: the buffer fills to 4 entries and o_rom_en drops to 0; on ready=1, PCs 0,1,2,3,4,... are delivered with no gap or duplicate.
REQ-035 Jump to 0x40 while 3 entries are buffered and one is in flight: no PC other than 0x40 onward appears; 0x40 is valid exactly 3 cycles after the jump cycle.
REQ-036 Fetch PC at 0x1FE, ready=1: PCs 0x1FE, 0x1FF, 0x000, 0x001 are delivered consecutively.
REQ-037 Jump to 0x10 then jump to 0x20 on the next cycle: first delivered PC 0x20; 0x10 is never delivered.
REQ-038 ROM word 0x7FF at address 5: o_instr=0x1FF when o_instr_pc=5, with the upper bits dropped.
